// File: rtl/banked_mem_ctrl.sv
// Banked ROM/SRAM controller with a Fibonacci-initialised ROM; 1-cycle response latency.
// Backpressure: req_ready is low while the post-reset SRAM clear runs, then high every cycle.
module banked_mem_ctrl #(
    parameter  int DATA_W  = 8,
    parameter  int BANK_AW = 3,
    parameter  int N_ROM   = 4,
    parameter  int N_SRAM  = 4,
    localparam int ADDR_W  = $clog2(N_ROM + N_SRAM) + BANK_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int N_BANK  = N_ROM + N_SRAM;
    localparam int BANK_W  = ADDR_W - BANK_AW;
    localparam int DEPTH   = 1 << BANK_AW;
    localparam int ROM_N   = N_ROM * DEPTH;
    localparam int SRAM_N  = N_SRAM * DEPTH;
    localparam int ROM_IW  = $clog2(ROM_N);
    localparam int SRAM_IW = $clog2(SRAM_N);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    function automatic logic [DATA_W-1:0] fib(input int k);
        logic [DATA_W-1:0] a, b, t;
        a = DATA_W'(1);
        b = DATA_W'(1);
        for (int i = 2; i <= k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    state_t               state_q, state_d;
    logic [SRAM_IW-1:0]   clr_ptr_q, clr_ptr_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]    sram_q [SRAM_N];
    logic [DATA_W-1:0]    rom_w  [ROM_N];

    logic [BANK_W-1:0]    bank;
    logic                 is_rom, is_sram, accept, wr_en;
    logic [ROM_IW-1:0]    rom_idx;
    logic [SRAM_IW-1:0]   sram_idx;

    for (genvar k = 0; k < ROM_N; k++) begin : g_rom
        assign rom_w[k] = fib(k);
    end

    // {bank, offset} is already the linear word index, so SRAM index is a plain subtract.
    assign bank     = req_addr[ADDR_W-1:BANK_AW];
    assign is_rom   = int'(bank) < N_ROM;
    assign is_sram  = !is_rom && (int'(bank) < N_BANK);
    assign rom_idx  = ROM_IW'(req_addr);
    assign sram_idx = SRAM_IW'(req_addr - ADDR_W'(ROM_N));
    assign accept   = req_valid && (state_q == ST_IDLE);
    assign wr_en    = accept && req_we && is_sram && rst_n;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_CLEAR) begin
            clr_ptr_d = clr_ptr_q + SRAM_IW'(1);
            if (clr_ptr_q == SRAM_IW'(SRAM_N - 1)) begin
                state_d   = ST_IDLE;
                clr_ptr_d = '0;
            end
        end
    end

    always_comb begin
        rsp_valid_d = accept;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (accept) begin
            if (is_rom) begin
                if (req_we) rsp_err_d   = 1'b1;
                else        rsp_rdata_d = rom_w[rom_idx];
            end else if (is_sram) begin
                if (!req_we) rsp_rdata_d = sram_q[sram_idx];
            end else begin
                rsp_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_ptr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR && rst_n) sram_q[clr_ptr_q] <= '0;
        else if (wr_en)                   sram_q[sram_idx]  <= req_wdata;
    end

    assign busy      = (state_q == ST_CLEAR);
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule
